// File: rtl/router_pkg.sv
// Shared MinBD router types: internal flit format, lane count default and side-buffer threshold.
package router_pkg;

  localparam int WIDTH_FLIT_INT   = 32;
  localparam int NUM_PORT_DEFAULT = 4;
  localparam int SIDE_BUF_CNT_TH  = 2;

  typedef struct packed {
    logic                        vld;
    logic [WIDTH_FLIT_INT-2:0]   payload;
  } flit_int_t;

endpackage

// File: rtl/slot_alloc.sv
// Finds the two lowest-index free lanes with two cascaded lowest-set-bit priority encoders.
module slot_alloc #(
  parameter int NUM_PORT = 4,
  parameter int IDX_W    = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1
) (
  input  logic [NUM_PORT-1:0] free,
  output logic [IDX_W-1:0]    s0_idx,
  output logic                s0_found,
  output logic [IDX_W-1:0]    s1_idx,
  output logic                s1_found
);

  logic [NUM_PORT-1:0] free_rem;

  // Scanning from the top down leaves the lowest set bit as the final winner.
  always_comb begin
    s0_idx   = '0;
    s0_found = 1'b0;
    for (int i = NUM_PORT - 1; i >= 0; i--) begin
      if (free[i]) begin
        s0_idx   = IDX_W'(i);
        s0_found = 1'b1;
      end
    end
  end

  always_comb begin
    free_rem = free;
    if (s0_found) free_rem[s0_idx] = 1'b0;
    s1_idx   = '0;
    s1_found = 1'b0;
    for (int i = NUM_PORT - 1; i >= 0; i--) begin
      if (free_rem[i]) begin
        s1_idx   = IDX_W'(i);
        s1_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/redirect_inject_stage.sv
// MinBD redirect/inject stage: fills free lanes from the side buffer then the core, swaps a flit out when starved.
// Optional statistics counters are enabled with the REDIRECT_STAT_EN macro.
module redirect_inject_stage
  import router_pkg::*;
#(
  parameter int NUM_PORT = NUM_PORT_DEFAULT
`ifdef REDIRECT_STAT_EN
  ,parameter int CNT_W   = 16
`endif
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  flit_int_t [NUM_PORT-1:0] din,
  input  flit_int_t                sb_head,
  input  logic                     sb_empty,
  input  logic                     sb_starve,
  input  flit_int_t                local_flit,
  input  logic                     local_vld,
  output logic                     local_gnt,
  output logic                     inject_gnt,
  output logic                     redirect_gnt,
  output flit_int_t                redirect_flit,
  output flit_int_t [NUM_PORT-1:0] dout
`ifdef REDIRECT_STAT_EN
  ,output logic [CNT_W-1:0]        redirect_cnt
  ,output logic [CNT_W-1:0]        inject_cnt
`endif
);

  localparam int IDX_W = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;

  logic [NUM_PORT-1:0]      free;
  logic [IDX_W-1:0]         s0_idx, s1_idx, local_lane;
  logic                     s0_found, s1_found, lane_found;
  logic                     case_a;
  logic [IDX_W-1:0]         rr_ptr, rr_next;
  flit_int_t [NUM_PORT-1:0] dout_next;

  always_comb begin
    for (int i = 0; i < NUM_PORT; i++) free[i] = ~din[i].vld;
  end

  slot_alloc #(
    .NUM_PORT (NUM_PORT),
    .IDX_W    (IDX_W)
  ) u_slot_alloc (
    .free     (free),
    .s0_idx   (s0_idx),
    .s0_found (s0_found),
    .s1_idx   (s1_idx),
    .s1_found (s1_found)
  );

  // An empty side buffer has nothing to swap in, so starvation alone never forces a redirect.
  assign case_a = sb_starve & ~sb_empty & ~(|free);

  always_comb begin
    inject_gnt    = 1'b0;
    redirect_gnt  = 1'b0;
    local_gnt     = 1'b0;
    redirect_flit = '0;
    dout_next     = din;
    rr_next       = rr_ptr;
    local_lane    = s0_idx;
    lane_found    = s0_found;
    if (n_rst) begin
      if (case_a) begin
        redirect_gnt      = 1'b1;
        inject_gnt        = 1'b1;
        redirect_flit     = din[rr_ptr];
        dout_next[rr_ptr] = sb_head;
        rr_next           = (rr_ptr == IDX_W'(NUM_PORT - 1)) ? '0 : rr_ptr + 1'b1;
      end else begin
        if (!sb_empty && s0_found) begin
          inject_gnt        = 1'b1;
          dout_next[s0_idx] = sb_head;
        end
        local_lane = inject_gnt ? s1_idx   : s0_idx;
        lane_found = inject_gnt ? s1_found : s0_found;
        if (local_vld && lane_found && !sb_starve) begin
          local_gnt             = 1'b1;
          dout_next[local_lane] = local_flit;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dout   <= '0;
      rr_ptr <= '0;
    end else begin
      dout   <= dout_next;
      rr_ptr <= rr_next;
    end
  end

`ifdef REDIRECT_STAT_EN
  // Saturating counters; inject_cnt only counts normal-path injections, not the swap half of a redirect.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      redirect_cnt <= '0;
      inject_cnt   <= '0;
    end else begin
      if (redirect_gnt && (redirect_cnt != {CNT_W{1'b1}}))
        redirect_cnt <= redirect_cnt + 1'b1;
      if (inject_gnt && !redirect_gnt && (inject_cnt != {CNT_W{1'b1}}))
        inject_cnt <= inject_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_redirect_inject_stage.sv
// Directed self-checking bench for redirect_inject_stage; counter checks run when REDIRECT_STAT_EN is defined.
module tb_redirect_inject_stage;
  import router_pkg::*;

  localparam int NP = NUM_PORT_DEFAULT;

  logic               clk;
  logic               n_rst;
  flit_int_t [NP-1:0] din;
  flit_int_t [NP-1:0] dout;
  flit_int_t          sb_head, local_flit, redirect_flit;
  logic               sb_empty, sb_starve, local_vld;
  logic               local_gnt, inject_gnt, redirect_gnt;
`ifdef REDIRECT_STAT_EN
  logic [3:0]         redirect_cnt, inject_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  redirect_inject_stage #(
    .NUM_PORT (NP)
`ifdef REDIRECT_STAT_EN
    ,.CNT_W   (4)
`endif
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .din           (din),
    .sb_head       (sb_head),
    .sb_empty      (sb_empty),
    .sb_starve     (sb_starve),
    .local_flit    (local_flit),
    .local_vld     (local_vld),
    .local_gnt     (local_gnt),
    .inject_gnt    (inject_gnt),
    .redirect_gnt  (redirect_gnt),
    .redirect_flit (redirect_flit),
    .dout          (dout)
`ifdef REDIRECT_STAT_EN
    ,.redirect_cnt (redirect_cnt)
    ,.inject_cnt   (inject_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic flit_int_t mk(input logic [30:0] p);
    flit_int_t f;
    f.vld     = 1'b1;
    f.payload = p;
    return f;
  endfunction

  // Inputs that would earn a local grant, to show reset forces every grant low.
  task automatic test_reset();
    n_rst = 1'b0; din = '0; sb_empty = 1'b1; sb_starve = 1'b0;
    local_vld = 1'b1; local_flit = mk(31'h5); sb_head = mk(31'h6);
    #2;
    checks++;
    if (dout !== '0) begin failures++; $display("[TB] FAIL reset_dout: got %h expected 0", dout); end
    checks++;
    if ({redirect_gnt, inject_gnt, local_gnt} !== 3'b000) begin
      failures++; $display("[TB] FAIL reset_gnt: got %b expected 000", {redirect_gnt, inject_gnt, local_gnt});
    end
    @(posedge clk); #1;
    checks++;
    if (dout !== '0) begin failures++; $display("[TB] FAIL reset_hold: got %h expected 0", dout); end
    n_rst = 1'b1;
  endtask

  task automatic test_local_only();
    flit_int_t [NP-1:0] exp;
    din = '0; sb_empty = 1'b1; sb_starve = 1'b0; local_vld = 1'b1;
    local_flit = mk(31'h11); sb_head = mk(31'h22);
    #2;
    checks++;
    if ({redirect_gnt, inject_gnt, local_gnt} !== 3'b001) begin
      failures++; $display("[TB] FAIL local_gnt: got %b expected 001", {redirect_gnt, inject_gnt, local_gnt});
    end
    checks++;
    if (redirect_flit !== '0) begin failures++; $display("[TB] FAIL local_rflit: got %h expected 0", redirect_flit); end
    exp = '0; exp[0] = local_flit;
    @(posedge clk); #1;
    checks++;
    if (dout !== exp) begin failures++; $display("[TB] FAIL local_dout: got %h expected %h", dout, exp); end
  endtask

  task automatic test_inject_local();
    flit_int_t [NP-1:0] exp;
    din = '0; din[1] = mk(31'h101); din[3] = mk(31'h103);
    sb_empty = 1'b0; sb_starve = 1'b0; local_vld = 1'b1;
    local_flit = mk(31'h33); sb_head = mk(31'h44);
    #2;
    checks++;
    if ({redirect_gnt, inject_gnt, local_gnt} !== 3'b011) begin
      failures++; $display("[TB] FAIL inj_loc_gnt: got %b expected 011", {redirect_gnt, inject_gnt, local_gnt});
    end
    exp[0] = mk(31'h44); exp[1] = mk(31'h101); exp[2] = mk(31'h33); exp[3] = mk(31'h103);
    @(posedge clk); #1;
    checks++;
    if (dout !== exp) begin failures++; $display("[TB] FAIL inj_loc_dout: got %h expected %h", dout, exp); end
  endtask

  task automatic test_starve_partial();
    flit_int_t [NP-1:0] exp;
    din = '0; din[1] = mk(31'h201); din[2] = mk(31'h202); din[3] = mk(31'h203);
    sb_empty = 1'b0; sb_starve = 1'b1; local_vld = 1'b1;
    local_flit = mk(31'h55); sb_head = mk(31'h66);
    #2;
    checks++;
    if ({redirect_gnt, inject_gnt, local_gnt} !== 3'b010) begin
      failures++; $display("[TB] FAIL starve_part_gnt: got %b expected 010", {redirect_gnt, inject_gnt, local_gnt});
    end
    exp = din; exp[0] = mk(31'h66);
    @(posedge clk); #1;
    checks++;
    if (dout !== exp) begin failures++; $display("[TB] FAIL starve_part_dout: got %h expected %h", dout, exp); end
  endtask

  // Five starved full cycles: victims 0,1,2,3 then wrap back to 0.
  task automatic test_redirect_rotation();
    flit_int_t [NP-1:0] exp;
    int victims[5] = '{0, 1, 2, 3, 0};
    sb_empty = 1'b0; sb_starve = 1'b1; local_vld = 1'b1; local_flit = mk(31'h77);
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < NP; i++) din[i] = mk(31'h300 + 31'(k * 16 + i));
      sb_head = mk(31'h400 + 31'(k));
      #2;
      checks++;
      if ({redirect_gnt, inject_gnt, local_gnt} !== 3'b110) begin
        failures++; $display("[TB] FAIL rot_gnt[%0d]: got %b expected 110", k, {redirect_gnt, inject_gnt, local_gnt});
      end
      checks++;
      if (redirect_flit !== din[victims[k]]) begin
        failures++; $display("[TB] FAIL rot_rflit[%0d]: got %h expected %h", k, redirect_flit, din[victims[k]]);
      end
      exp = din; exp[victims[k]] = sb_head;
      @(posedge clk); #1;
      checks++;
      if (dout !== exp) begin failures++; $display("[TB] FAIL rot_dout[%0d]: got %h expected %h", k, dout, exp); end
    end
  endtask

  // rr_ptr sits at 1 here; two swaps, then reset mid-stream must clear dout and return the victim to lane 0.
  task automatic test_reset_mid();
    flit_int_t [NP-1:0] exp;
    int victims[2] = '{1, 2};
    sb_empty = 1'b0; sb_starve = 1'b1; local_vld = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NP; i++) din[i] = mk(31'h500 + 31'(k * 16 + i));
      sb_head = mk(31'h600 + 31'(k));
      #2;
      checks++;
      if (redirect_flit !== din[victims[k]]) begin
        failures++; $display("[TB] FAIL mid_rflit[%0d]: got %h expected %h", k, redirect_flit, din[victims[k]]);
      end
      @(posedge clk); #1;
    end
    n_rst = 1'b0;
    #1;
    checks++;
    if (dout !== '0) begin failures++; $display("[TB] FAIL mid_rst_dout: got %h expected 0", dout); end
    checks++;
    if ({redirect_gnt, inject_gnt, local_gnt, redirect_flit} !== '0) begin
      failures++; $display("[TB] FAIL mid_rst_gnt: got %b/%h expected 000/0", {redirect_gnt, inject_gnt, local_gnt}, redirect_flit);
    end
    @(posedge clk); #1;
    n_rst = 1'b1;
    for (int i = 0; i < NP; i++) din[i] = mk(31'h700 + 31'(i));
    sb_head = mk(31'h7ff);
    #2;
    checks++;
    if (redirect_flit !== din[0]) begin failures++; $display("[TB] FAIL mid_after_rflit: got %h expected %h", redirect_flit, din[0]); end
    exp = din; exp[0] = sb_head;
    @(posedge clk); #1;
    checks++;
    if (dout !== exp) begin failures++; $display("[TB] FAIL mid_after_dout: got %h expected %h", dout, exp); end
  endtask

  task automatic test_back_to_back();
    flit_int_t [NP-1:0] exp;
    din = '0; sb_empty = 1'b0; sb_starve = 1'b0; local_vld = 1'b1;
    sb_head = mk(31'h811); local_flit = mk(31'h822);
    #2;
    checks++;
    if ({redirect_gnt, inject_gnt, local_gnt} !== 3'b011) begin
      failures++; $display("[TB] FAIL b2b0_gnt: got %b expected 011", {redirect_gnt, inject_gnt, local_gnt});
    end
    exp = '0; exp[0] = sb_head; exp[1] = local_flit;
    @(posedge clk); #1;
    checks++;
    if (dout !== exp) begin failures++; $display("[TB] FAIL b2b0_dout: got %h expected %h", dout, exp); end
    for (int i = 0; i < NP; i++) din[i] = mk(31'h900 + 31'(i));
    #2;
    checks++;
    if ({redirect_gnt, inject_gnt, local_gnt} !== 3'b000) begin
      failures++; $display("[TB] FAIL b2b1_gnt: got %b expected 000", {redirect_gnt, inject_gnt, local_gnt});
    end
    exp = din;
    @(posedge clk); #1;
    checks++;
    if (dout !== exp) begin failures++; $display("[TB] FAIL b2b1_dout: got %h expected %h", dout, exp); end
    din[3] = '0; sb_head = mk(31'h933);
    #2;
    checks++;
    if ({redirect_gnt, inject_gnt, local_gnt} !== 3'b010) begin
      failures++; $display("[TB] FAIL b2b2_gnt: got %b expected 010", {redirect_gnt, inject_gnt, local_gnt});
    end
    exp = din; exp[3] = sb_head;
    @(posedge clk); #1;
    checks++;
    if (dout !== exp) begin failures++; $display("[TB] FAIL b2b2_dout: got %h expected %h", dout, exp); end
  endtask

`ifdef REDIRECT_STAT_EN
  task automatic test_stat_counters();
    n_rst = 1'b0; #1;
    checks++;
    if ({redirect_cnt, inject_cnt} !== 8'h00) begin
      failures++; $display("[TB] FAIL cnt_reset: got %h/%h expected 0/0", redirect_cnt, inject_cnt);
    end
    n_rst = 1'b1;
    din = '0; sb_empty = 1'b0; sb_starve = 1'b0; local_vld = 1'b0; sb_head = mk(31'ha00);
    @(posedge clk); #1;
    for (int i = 0; i < NP; i++) din[i] = mk(31'ha10 + 31'(i));
    sb_starve = 1'b1;
    for (int k = 0; k < 17; k++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (redirect_cnt !== 4'hf) begin failures++; $display("[TB] FAIL redirect_cnt_sat: got %0d expected 15", redirect_cnt); end
    checks++;
    if (inject_cnt !== 4'h1) begin failures++; $display("[TB] FAIL inject_cnt: got %0d expected 1", inject_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_local_only();
    test_inject_local();
    test_starve_partial();
    test_redirect_rotation();
    test_reset_mid();
    test_back_to_back();
`ifdef REDIRECT_STAT_EN
    test_stat_counters();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
